// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU.
// Captures decoded operands and control, decodes the 4-bit ALU select, resolves
// EX/MEM and MEM/WB forwarding on the registered sources, detects load-use hazards
// and inserts bubbles on flush, hazard or an idle decode slot.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   id_*_i                  decode-stage instruction fields and control
//   stall_i, flush_i        external hold / squash requests
//   exm_*_i, mwb_*_i        downstream destination, write enable and result for forwarding
//   op1_o, op2_o, alu_sel_o final ALU operands and select
//   store_data_o            forwarded rt value for stores
//   ex_*_o                  registered EX-stage valid, destination and control
//   hazard_o                load-use stall request to IF/ID
module id_ex_stage #(
  parameter int unsigned W  = 32,
  parameter int unsigned RA = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          id_valid_i,
  input  logic [W-1:0]  id_rs_data_i,
  input  logic [W-1:0]  id_rt_data_i,
  input  logic [15:0]   id_imm_i,
  input  logic [RA-1:0] id_rs_i,
  input  logic [RA-1:0] id_rt_i,
  input  logic [RA-1:0] id_rd_i,
  input  logic [5:0]    id_funct_i,
  input  logic [2:0]    id_alu_op_i,
  input  logic          id_alu_src_i,
  input  logic          id_sign_ext_i,
  input  logic          id_reg_dst_i,
  input  logic          id_reg_write_i,
  input  logic          id_mem_read_i,
  input  logic          id_mem_write_i,
  input  logic          id_mem_to_reg_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [RA-1:0] exm_dst_i,
  input  logic          exm_wr_i,
  input  logic [W-1:0]  exm_res_i,
  input  logic [RA-1:0] mwb_dst_i,
  input  logic          mwb_wr_i,
  input  logic [W-1:0]  mwb_res_i,
  output logic [W-1:0]  op1_o,
  output logic [W-1:0]  op2_o,
  output logic [3:0]    alu_sel_o,
  output logic [W-1:0]  store_data_o,
  output logic          ex_valid_o,
  output logic [RA-1:0] ex_dst_o,
  output logic          ex_reg_write_o,
  output logic          ex_mem_read_o,
  output logic          ex_mem_write_o,
  output logic          ex_mem_to_reg_o,
  output logic          hazard_o
);

  localparam logic [3:0] SelNop = 4'b1000;

  typedef struct packed {
    logic          valid;
    logic [RA-1:0] rs;
    logic [RA-1:0] rt;
    logic [RA-1:0] dst;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } ex_t;

  // A bubble is ex_q == '0 together with sel_q == SelNop.
  ex_t        ex_q, ex_d;
  logic [3:0] sel_q, sel_d;

  logic [3:0]   dec_sel;
  logic         dec_ok;
  logic [W-1:0] imm_ext;
  logic [W-1:0] rs_fwd, rt_fwd;

  assign imm_ext = id_sign_ext_i ? {{(W-16){id_imm_i[15]}}, id_imm_i} : {{(W-16){1'b0}}, id_imm_i};

  // ALU select decode; an unrecognised R-type funct becomes a nop that never writes back.
  always_comb begin
    dec_sel = SelNop;
    dec_ok  = 1'b1;
    case (id_alu_op_i)
      3'b000: dec_sel = 4'b0010;
      3'b001: dec_sel = 4'b0110;
      3'b010: begin
        case (id_funct_i)
          6'h24:        dec_sel = 4'b0000;
          6'h25:        dec_sel = 4'b0001;
          6'h20, 6'h21: dec_sel = 4'b0010;
          6'h18:        dec_sel = 4'b0011;
          6'h1A:        dec_sel = 4'b0100;
          6'h26:        dec_sel = 4'b0101;
          6'h22, 6'h23: dec_sel = 4'b0110;
          6'h2A:        dec_sel = 4'b0111;
          default:      dec_ok  = 1'b0;
        endcase
      end
      3'b011: dec_sel = 4'b0000;
      3'b100: dec_sel = 4'b0001;
      3'b101: dec_sel = 4'b0101;
      3'b110: dec_sel = 4'b0111;
      default: dec_sel = SelNop;
    endcase
  end

  // Stores read rt in EX too, so an rt match matters even when OP2 is the immediate.
  assign hazard_o = ex_q.valid & ex_q.mem_read & id_valid_i & (ex_q.dst != '0) &
                    ((ex_q.dst == id_rs_i) |
                     ((ex_q.dst == id_rt_i) & (~id_alu_src_i | id_mem_write_i)));

  always_comb begin
    ex_d  = ex_q;
    sel_d = sel_q;
    if (flush_i || (!stall_i && (hazard_o || !id_valid_i))) begin
      ex_d  = '0;
      sel_d = SelNop;
    end else if (!stall_i) begin
      ex_d.valid      = 1'b1;
      ex_d.rs         = id_rs_i;
      ex_d.rt         = id_rt_i;
      ex_d.dst        = id_reg_dst_i ? id_rd_i : id_rt_i;
      ex_d.rs_data    = id_rs_data_i;
      ex_d.rt_data    = id_rt_data_i;
      ex_d.imm        = imm_ext;
      ex_d.alu_src    = id_alu_src_i;
      ex_d.reg_write  = id_reg_write_i & dec_ok;
      ex_d.mem_read   = id_mem_read_i;
      ex_d.mem_write  = id_mem_write_i;
      ex_d.mem_to_reg = id_mem_to_reg_i;
      sel_d           = dec_sel;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      sel_q <= SelNop;
    end else begin
      ex_q  <= ex_d;
      sel_q <= sel_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never forwarded.
  always_comb begin
    rs_fwd = ex_q.rs_data;
    if (exm_wr_i && (exm_dst_i != '0) && (exm_dst_i == ex_q.rs)) begin
      rs_fwd = exm_res_i;
    end else if (mwb_wr_i && (mwb_dst_i != '0) && (mwb_dst_i == ex_q.rs)) begin
      rs_fwd = mwb_res_i;
    end
    rt_fwd = ex_q.rt_data;
    if (exm_wr_i && (exm_dst_i != '0) && (exm_dst_i == ex_q.rt)) begin
      rt_fwd = exm_res_i;
    end else if (mwb_wr_i && (mwb_dst_i != '0) && (mwb_dst_i == ex_q.rt)) begin
      rt_fwd = mwb_res_i;
    end
  end

  // Bubbles present zero operands so the ALU zero flag is deterministic.
  assign op1_o           = ex_q.valid ? rs_fwd : '0;
  assign op2_o           = ex_q.valid ? (ex_q.alu_src ? ex_q.imm : rt_fwd) : '0;
  assign alu_sel_o       = sel_q;
  assign store_data_o    = rt_fwd;
  assign ex_valid_o      = ex_q.valid;
  assign ex_dst_o        = ex_q.dst;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// against a behavioural model of the EX-stage contents.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [2:0]  id_alu_op;
  logic        id_alu_src, id_sign_ext, id_reg_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic [4:0]  exm_dst, mwb_dst;
  logic        exm_wr, mwb_wr;
  logic [31:0] exm_res, mwb_res;
  logic [31:0] op1, op2, store_data;
  logic [3:0]  alu_sel;
  logic        ex_valid;
  logic [4:0]  ex_dst;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        hazard;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.W(32), .RA(5)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_funct_i(id_funct),
    .id_alu_op_i(id_alu_op), .id_alu_src_i(id_alu_src), .id_sign_ext_i(id_sign_ext),
    .id_reg_dst_i(id_reg_dst), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .id_mem_write_i(id_mem_write), .id_mem_to_reg_i(id_mem_to_reg),
    .stall_i(stall), .flush_i(flush),
    .exm_dst_i(exm_dst), .exm_wr_i(exm_wr), .exm_res_i(exm_res),
    .mwb_dst_i(mwb_dst), .mwb_wr_i(mwb_wr), .mwb_res_i(mwb_res),
    .op1_o(op1), .op2_o(op2), .alu_sel_o(alu_sel), .store_data_o(store_data),
    .ex_valid_o(ex_valid), .ex_dst_o(ex_dst), .ex_reg_write_o(ex_reg_write),
    .ex_mem_read_o(ex_mem_read), .ex_mem_write_o(ex_mem_write),
    .ex_mem_to_reg_o(ex_mem_to_reg), .hazard_o(hazard)
  );

  // ---------------- behavioural model of the EX slot ----------------
  logic        m_valid, m_src, m_rw, m_mr, m_mw, m_mtr;
  logic [3:0]  m_sel;
  logic [4:0]  m_rs, m_rt, m_dst;
  logic [31:0] m_rsd, m_rtd, m_imm;

  // Returns {writes_allowed, sel}.
  function automatic logic [4:0] ref_sel(input logic [2:0] op, input logic [5:0] fn);
    logic [3:0] by_op [8];
    by_op = '{4'd2, 4'd6, 4'd8, 4'd0, 4'd1, 4'd5, 4'd7, 4'd8};
    if (op != 3'd2) return {1'b1, by_op[op]};
    if (fn == 6'h24) return 5'h10;
    if (fn == 6'h25) return 5'h11;
    if (fn == 6'h20 || fn == 6'h21) return 5'h12;
    if (fn == 6'h18) return 5'h13;
    if (fn == 6'h1A) return 5'h14;
    if (fn == 6'h26) return 5'h15;
    if (fn == 6'h22 || fn == 6'h23) return 5'h16;
    if (fn == 6'h2A) return 5'h17;
    return 5'h08;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 0) return v;
    if (exm_wr && exm_dst == r) return exm_res;
    if (mwb_wr && mwb_dst == r) return mwb_res;
    return v;
  endfunction

  function automatic logic ref_hazard();
    if (!(m_valid && m_mr && id_valid) || m_dst == 0) return 1'b0;
    if (m_dst == id_rs) return 1'b1;
    return (m_dst == id_rt) && (!id_alu_src || id_mem_write);
  endfunction

  task automatic model_bubble();
    {m_valid, m_src, m_rw, m_mr, m_mw, m_mtr} = '0;
    {m_rs, m_rt, m_dst, m_rsd, m_rtd, m_imm} = '0;
    m_sel = 4'd8;
  endtask

  // Apply one clock edge to the model using the current inputs.
  task automatic model_edge();
    logic [4:0] s;
    if (flush) model_bubble();
    else if (stall) ;
    else if (ref_hazard() || !id_valid) model_bubble();
    else begin
      s = ref_sel(id_alu_op, id_funct);
      m_valid = 1'b1; m_sel = s[3:0];
      m_rs = id_rs; m_rt = id_rt; m_rsd = id_rs_data; m_rtd = id_rt_data;
      m_dst = id_reg_dst ? id_rd : id_rt;
      m_imm = (id_sign_ext && id_imm >= 16'h8000) ? (32'hFFFF0000 + id_imm) : 32'(id_imm);
      m_src = id_alu_src; m_rw = id_reg_write & s[4];
      m_mr = id_mem_read; m_mw = id_mem_write; m_mtr = id_mem_to_reg;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_funct = 0; id_alu_op = 3'b111;
    id_alu_src = 0; id_sign_ext = 0; id_reg_dst = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    stall = 0; flush = 0;
    exm_dst = 0; exm_wr = 0; exm_res = 0; mwb_dst = 0; mwb_wr = 0; mwb_res = 0;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; idle_inputs();
    #2;
    checks++;
    if ({ex_valid, alu_sel, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard}
        !== {1'b0, 4'b1000, 5'd0, 5'b0}) begin
      failures++;
      $display("FAIL reset_ctrl got valid=%b sel=%b dst=%0d haz=%b", ex_valid, alu_sel, ex_dst,
               hazard);
    end
    checks++;
    if ({op1, op2, store_data} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data got op1=%h op2=%h st=%h want 0", op1, op2, store_data);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_rtype_add();
    @(negedge clk);
    id_valid = 1; id_rs_data = 5; id_rt_data = 7; id_alu_op = 3'b010; id_funct = 6'h20;
    id_reg_dst = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_reg_write = 1;
    edge_settle();
    checks++;
    if ({op1, op2, alu_sel, ex_dst, ex_valid, ex_reg_write} !== {32'd5, 32'd7, 4'b0010, 5'd3, 2'b11})
    begin
      failures++;
      $display("FAIL rtype_add got op1=%0d op2=%0d sel=%b dst=%0d v=%b rw=%b want 5 7 0010 3 1 1",
               op1, op2, alu_sel, ex_dst, ex_valid, ex_reg_write);
    end
  endtask

  task automatic test_imm_ext();
    @(negedge clk);
    id_alu_op = 3'b000; id_alu_src = 1; id_imm = 16'hFFFE; id_sign_ext = 1;
    edge_settle();
    checks++;
    if ({op2, alu_sel} !== {32'hFFFFFFFE, 4'b0010}) begin
      failures++;
      $display("FAIL imm_sign got op2=%h sel=%b want fffffffe 0010", op2, alu_sel);
    end
    @(negedge clk); id_sign_ext = 0;
    edge_settle();
    checks++;
    if (op2 !== 32'h0000FFFE) begin
      failures++;
      $display("FAIL imm_zero got op2=%h want 0000fffe", op2);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    id_rs = 4; id_rs_data = 7; id_rt = 4; id_rt_data = 8; id_imm = 16'h0011; id_alu_src = 1;
    exm_wr = 1; exm_dst = 4; exm_res = 100; mwb_wr = 1; mwb_dst = 4; mwb_res = 200;
    edge_settle();
    checks++;
    if ({op1, op2, store_data} !== {32'd100, 32'h11, 32'd100}) begin
      failures++;
      $display("FAIL fwd_exm got op1=%0d op2=%h st=%0d want 100 11 100", op1, op2, store_data);
    end
    exm_wr = 0; #1;
    checks++;
    if ({op1, store_data} !== {32'd200, 32'd200}) begin
      failures++;
      $display("FAIL fwd_mwb got op1=%0d st=%0d want 200 200", op1, store_data);
    end
    mwb_wr = 0; #1;
    checks++;
    if ({op1, store_data} !== {32'd7, 32'd8}) begin
      failures++;
      $display("FAIL fwd_none got op1=%0d st=%0d want 7 8", op1, store_data);
    end
    @(negedge clk);
    id_rs = 0; id_rs_data = 9; id_rt = 0; id_rt_data = 10; id_alu_src = 0;
    exm_wr = 1; exm_dst = 0; mwb_wr = 1; mwb_dst = 0;
    edge_settle();
    checks++;
    if ({op1, op2} !== {32'd9, 32'd10}) begin
      failures++;
      $display("FAIL fwd_r0 got op1=%0d op2=%0d want 9 10", op1, op2);
    end
    exm_wr = 0; mwb_wr = 0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_alu_op = 3'b000; id_alu_src = 1; id_rt = 8; id_rs = 2; id_mem_read = 1;
    id_reg_write = 1; id_mem_to_reg = 1;
    edge_settle();
    checks++;
    if ({ex_mem_read, ex_dst, ex_mem_to_reg} !== {1'b1, 5'd8, 1'b1}) begin
      failures++;
      $display("FAIL lw_load got mr=%b dst=%0d mtr=%b want 1 8 1", ex_mem_read, ex_dst,
               ex_mem_to_reg);
    end
    @(negedge clk);
    id_rs = 8; id_rt = 1; id_alu_src = 0; id_mem_read = 0; id_mem_to_reg = 0;
    id_alu_op = 3'b010; id_funct = 6'h20; id_rs_data = 55; id_rt_data = 66;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++;
      $display("FAIL lu_hazard_rs got %b want 1", hazard);
    end
    edge_settle();
    checks++;
    if ({ex_valid, alu_sel, op1, op2, hazard} !== {1'b0, 4'b1000, 64'd0, 1'b0}) begin
      failures++;
      $display("FAIL lu_bubble got v=%b sel=%b op1=%h op2=%h haz=%b", ex_valid, alu_sel, op1, op2,
               hazard);
    end
    edge_settle();
    checks++;
    if ({ex_valid, op1, op2} !== {1'b1, 32'd55, 32'd66}) begin
      failures++;
      $display("FAIL lu_retry got v=%b op1=%0d op2=%0d want 1 55 66", ex_valid, op1, op2);
    end
    // rt-only matches: immediate ALU op does not stall unless it is a store.
    @(negedge clk);
    id_alu_op = 3'b000; id_alu_src = 1; id_rt = 8; id_rs = 2; id_mem_read = 1;
    edge_settle();
    @(negedge clk);
    id_mem_read = 0; id_rs = 1; id_rt = 8; id_alu_src = 1; id_mem_write = 0;
    #1;
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL lu_imm_rt got %b want 0", hazard);
    end
    id_mem_write = 1; #1;
    checks++;
    if (hazard !== 1'b1) begin
      failures++;
      $display("FAIL lu_store_rt got %b want 1", hazard);
    end
    id_valid = 0; #1;
    checks++;
    if (hazard !== 1'b0) begin
      failures++;
      $display("FAIL lu_id_invalid got %b want 0", hazard);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_alu_op = 3'b001; id_rs = 1; id_rt = 2; id_rs_data = 20; id_rt_data = 3;
    id_reg_write = 1;
    edge_settle();
    @(negedge clk);
    stall = 1; id_rs_data = 99; id_alu_op = 3'b100;
    for (int i = 0; i < 3; i++) begin
      edge_settle();
      checks++;
      if ({ex_valid, alu_sel, op1, op2, ex_reg_write} !== {1'b1, 4'b0110, 32'd20, 32'd3, 1'b1})
      begin
        failures++;
        $display("FAIL stall_hold[%0d] got v=%b sel=%b op1=%0d op2=%0d", i, ex_valid, alu_sel, op1,
                 op2);
      end
    end
    @(negedge clk); flush = 1;
    edge_settle();
    checks++;
    if ({ex_valid, alu_sel, op1, ex_reg_write} !== {1'b0, 4'b1000, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL flush_over_stall got v=%b sel=%b op1=%0d", ex_valid, alu_sel, op1);
    end
    @(negedge clk); stall = 0; flush = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_alu_op = 3'b011; id_rs_data = 6; id_rt_data = 3; id_rs = 1; id_rt = 2;
    edge_settle();
    checks++;
    if ({ex_valid, alu_sel} !== {1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL and_load got v=%b sel=%b want 1 0000", ex_valid, alu_sel);
    end
    stall = 1;
    @(negedge clk); #2 rst = 1; #1;
    checks++;
    if ({ex_valid, alu_sel, op1, op2} !== {1'b0, 4'b1000, 64'd0}) begin
      failures++;
      $display("FAIL async_reset got v=%b sel=%b op1=%0d op2=%0d", ex_valid, alu_sel, op1, op2);
    end
    @(negedge clk); rst = 0; stall = 0;
    id_alu_op = 3'b010; id_funct = 6'h3F; id_reg_write = 1;
    edge_settle();
    checks++;
    if ({ex_valid, alu_sel, ex_reg_write, op1} !== {1'b1, 4'b1000, 1'b0, 32'd6}) begin
      failures++;
      $display("FAIL bad_funct got v=%b sel=%b rw=%b op1=%0d want 1 1000 0 6", ex_valid, alu_sel,
               ex_reg_write, op1);
    end
  endtask

  task automatic test_random();
    logic [5:0]  known [10];
    logic [31:0] e_st, e_op1, e_op2;
    known = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h18, 6'h1A, 6'h26, 6'h22, 6'h23, 6'h2A};
    @(negedge clk);
    idle_inputs(); rst = 1;
    @(negedge clk); rst = 0;
    model_bubble();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      id_valid = ($urandom_range(0, 9) < 8);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_alu_op = 3'($urandom);
      id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : known[$urandom_range(0, 9)];
      {id_alu_src, id_sign_ext, id_reg_dst, id_reg_write} = 4'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = ($urandom_range(0, 3) == 0);
      id_mem_to_reg = 1'($urandom);
      stall = ($urandom_range(0, 9) == 0); flush = ($urandom_range(0, 14) == 0);
      exm_wr = 1'($urandom); exm_dst = 5'($urandom_range(0, 7)); exm_res = $urandom;
      mwb_wr = 1'($urandom); mwb_dst = 5'($urandom_range(0, 7)); mwb_res = $urandom;
      #1;
      e_st  = ref_fwd(m_rt, m_rtd);
      e_op1 = m_valid ? ref_fwd(m_rs, m_rsd) : 32'd0;
      e_op2 = m_valid ? (m_src ? m_imm : e_st) : 32'd0;
      checks++;
      if (hazard !== ref_hazard()) begin
        failures++;
        $display("FAIL rnd_hazard cyc=%0d got %b want %b", i, hazard, ref_hazard());
      end
      checks++;
      if ({ex_valid, alu_sel, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}
          !== {m_valid, m_sel, m_dst, m_rw, m_mr, m_mw, m_mtr}) begin
        failures++;
        $display("FAIL rnd_ctrl cyc=%0d got v=%b sel=%b dst=%0d c=%b%b%b%b want %b %b %0d %b%b%b%b",
                 i, ex_valid, alu_sel, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write,
                 ex_mem_to_reg, m_valid, m_sel, m_dst, m_rw, m_mr, m_mw, m_mtr);
      end
      checks++;
      if ({op1, op2, store_data} !== {e_op1, e_op2, e_st}) begin
        failures++;
        $display("FAIL rnd_data cyc=%0d got %h %h %h want %h %h %h", i, op1, op2, store_data,
                 e_op1, e_op2, e_st);
      end
      model_edge();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype_add();
    test_imm_ext();
    test_forward();
    test_load_use();
    test_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
